// File: rtl/axi_rd_lat_mon.sv
// Passive AXI read-latency monitor: tracks outstanding AR requests by ID and accumulates latency statistics.
// Latency: statistics and outstanding are registered and reflect a handshake one cycle after it.
// Backpressure: none; the block only snoops the AR/R handshakes and never drives ready or valid.
module axi_rd_lat_mon #(
  parameter int ID_WIDTH             = 8,
  parameter int LOG_OUTSTAND         = 5,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 5,
  parameter int CNT_WIDTH            = 32,
  parameter int LAT_WIDTH            = 16
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       ar_valid,
  input  logic                       ar_ready,
  input  logic [ID_WIDTH-1:0]        ar_id,
  input  logic [BURST_LEN_WIDTH-1:0] ar_len,
  input  logic                       r_valid,
  input  logic                       r_ready,
  input  logic                       r_last,
  input  logic [ID_WIDTH-1:0]        r_id,
  output logic [CNT_WIDTH-1:0]       req_cnt,
  output logic [CNT_WIDTH-1:0]       resp_cnt,
  output logic [CNT_WIDTH-1:0]       beat_cnt,
  output logic [CNT_WIDTH-1:0]       lat_sum,
  output logic [LAT_WIDTH-1:0]       lat_min,
  output logic [LAT_WIDTH-1:0]       lat_max,
  output logic [LOG_OUTSTAND:0]      outstanding,
  output logic                       err_overflow,
  output logic                       err_orphan
);
  localparam int L = LOG_OUTSTAND;
  localparam int N = 1 << LOG_OUTSTAND;

  // Burst length and beat size do not affect tracking; bytes are derived outside.
  logic unused_cfg;
  assign unused_cfg = (^ar_len) ^ LOG_BLOCK_DATA_BYTES[0];

  // Pointers carry one extra wrap bit so a full window (tail - head == N) differs from an empty one.
  logic [L:0]           head_q, head_d, tail_q, tail_d;
  logic [N-1:0]         valid_q, valid_d;
  logic [ID_WIDTH-1:0]  id_q    [N];
  logic [LAT_WIDTH-1:0] start_q [N];
  logic [LAT_WIDTH-1:0] ts_q, ts_d;

  logic [CNT_WIDTH-1:0] req_q, req_d, resp_q, resp_d, beat_q, beat_d, sum_q, sum_d;
  logic [LAT_WIDTH-1:0] min_q, min_d, max_q, max_d;
  logic [L:0]           out_q, out_d;
  logic                 ovf_q, ovf_d, orph_q, orph_d;

  logic                 ar_hs, r_beat, r_done, alloc, drop, hit, orphan, head_adv;
  logic [L-1:0]         head_idx, tail_idx, idx, match_idx;
  logic                 found;
  logic [LAT_WIDTH-1:0] lat;
  logic [CNT_WIDTH:0]   lat_ext, sum_wide;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign ar_hs    = ar_valid & ar_ready & en;
  assign r_beat   = r_valid & r_ready & en;
  assign r_done   = r_beat & r_last;
  assign head_idx = head_q[L-1:0];
  assign tail_idx = tail_q[L-1:0];
  // Fullness is judged on the pre-cycle tail entry, so a same-cycle retirement never frees it for this AR.
  assign alloc    = ar_hs & ~valid_q[tail_idx];
  assign drop     = ar_hs & valid_q[tail_idx];
  assign head_adv = (head_q != tail_q) & ~valid_q[head_idx];

  // Oldest valid entry with a matching ID, walking from head; the entry allocated this cycle is not yet valid.
  always_comb begin
    found     = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = head_idx + L'(k);
      if (!found && valid_q[idx] && (id_q[idx] == r_id)) begin
        found     = 1'b1;
        match_idx = idx;
      end
    end
  end

  assign hit      = r_done & found;
  assign orphan   = r_done & ~found;
  assign lat      = ts_q - start_q[match_idx];
  assign lat_ext  = {{(CNT_WIDTH + 1 - LAT_WIDTH){1'b0}}, lat};
  assign sum_wide = {1'b0, sum_q} + lat_ext;

  // Next-state for the table pointers, valid bits and all statistics; clear overrides every event.
  always_comb begin
    ts_d    = ts_q + LAT_WIDTH'(1);
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    req_d   = req_q;
    resp_d  = resp_q;
    beat_d  = beat_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    orph_d  = orph_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      req_d   = '0;
      resp_d  = '0;
      beat_d  = '0;
      sum_d   = '0;
      min_d   = '1;
      max_d   = '0;
      out_d   = '0;
      ovf_d   = 1'b0;
      orph_d  = 1'b0;
    end else begin
      if (alloc) begin
        valid_d[tail_idx] = 1'b1;
        tail_d            = tail_q + (L+1)'(1);
        req_d             = sat_inc(req_q);
      end
      if (drop)   ovf_d  = 1'b1;
      if (orphan) orph_d = 1'b1;
      if (hit) begin
        valid_d[match_idx] = 1'b0;
        resp_d             = sat_inc(resp_q);
        sum_d              = sum_wide[CNT_WIDTH] ? '1 : sum_wide[CNT_WIDTH-1:0];
        if (lat < min_q) min_d = lat;
        if (lat > max_q) max_d = lat;
      end
      if (r_beat)   beat_d = sat_inc(beat_q);
      if (head_adv) head_d = head_q + (L+1)'(1);
      if (alloc && !hit)      out_d = out_q + (L+1)'(1);
      else if (!alloc && hit) out_d = out_q - (L+1)'(1);
    end
  end

  // State register; reset brings everything to the cleared state and restarts the timestamp.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ts_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      req_q   <= '0;
      resp_q  <= '0;
      beat_q  <= '0;
      sum_q   <= '0;
      min_q   <= '1;
      max_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      orph_q  <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
      beat_q  <= beat_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      orph_q  <= orph_d;
    end
  end

  // Entry payload needs no reset: it is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc) begin
      id_q[tail_idx]    <= ar_id;
      start_q[tail_idx] <= ts_q;
    end
  end

  assign req_cnt      = req_q;
  assign resp_cnt     = resp_q;
  assign beat_cnt     = beat_q;
  assign lat_sum      = sum_q;
  assign lat_min      = min_q;
  assign lat_max      = max_q;
  assign outstanding  = out_q;
  assign err_overflow = ovf_q;
  assign err_orphan   = orph_q;

endmodule

// File: tb/tb_axi_rd_lat_mon.sv
module tb_axi_rd_lat_mon;
  localparam int  NE   = 32;
  localparam longint CMAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        en = 1'b1, clear = 1'b0;
  logic        ar_valid = 1'b0, ar_ready = 1'b0;
  logic [7:0]  ar_id = '0, ar_len = '0;
  logic        r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
  logic [7:0]  r_id = '0;
  logic [31:0] req_cnt, resp_cnt, beat_cnt, lat_sum;
  logic [15:0] lat_min, lat_max;
  logic [5:0]  outstanding;
  logic        err_overflow, err_orphan;

  axi_rd_lat_mon dut (
    .clk(clk), .resetN(resetN), .en(en), .clear(clear),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last), .r_id(r_id),
    .req_cnt(req_cnt), .resp_cnt(resp_cnt), .beat_cnt(beat_cnt), .lat_sum(lat_sum),
    .lat_min(lat_min), .lat_max(lat_max), .outstanding(outstanding),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slots hold {valid, id, start time, allocation order}; the match for a
  // completion is the oldest-allocated valid slot with that id.
  bit     m_v   [NE];
  int     m_id  [NE];
  int     m_start [NE];
  longint m_seq [NE];
  int     m_tail = 0;
  longint m_seqn = 0;
  int     m_ts = 0;
  longint e_req = 0, e_resp = 0, e_beat = 0, e_sum = 0;
  int     e_min = 'hFFFF, e_max = 0, e_out = 0;
  bit     e_ovf = 0, e_orph = 0;

  function automatic longint sat(input longint x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_flush();
    for (int s = 0; s < NE; s++) m_v[s] = 1'b0;
    m_tail = 0;
    e_req = 0; e_resp = 0; e_beat = 0; e_sum = 0;
    e_min = 'hFFFF; e_max = 0; e_out = 0; e_ovf = 0; e_orph = 0;
  endtask

  task automatic model_step();
    bit a, rb, rd, full;
    int best, lat, cnt;
    a  = ar_valid && ar_ready && en;
    rb = r_valid && r_ready && en;
    rd = rb && r_last;
    if (clear) begin
      model_flush();
    end else begin
      full = m_v[m_tail];
      best = -1;
      for (int s = 0; s < NE; s++)
        if (m_v[s] && m_id[s] == int'(r_id) && (best < 0 || m_seq[s] < m_seq[best])) best = s;
      if (rd) begin
        if (best >= 0) begin
          lat = (m_ts - m_start[best]) & 'hFFFF;
          m_v[best] = 1'b0;
          e_resp = sat(e_resp + 1);
          e_sum  = sat(e_sum + lat);
          if (lat < e_min) e_min = lat;
          if (lat > e_max) e_max = lat;
        end else begin
          e_orph = 1'b1;
        end
      end
      if (a) begin
        if (!full) begin
          m_v[m_tail] = 1'b1;
          m_id[m_tail] = int'(ar_id);
          m_start[m_tail] = m_ts;
          m_seq[m_tail] = m_seqn;
          m_seqn++;
          m_tail = (m_tail + 1) % NE;
          e_req = sat(e_req + 1);
        end else begin
          e_ovf = 1'b1;
        end
      end
      if (rb) e_beat = sat(e_beat + 1);
      cnt = 0;
      for (int s = 0; s < NE; s++) if (m_v[s]) cnt++;
      e_out = cnt;
    end
    m_ts++;
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      model_flush();
      m_ts = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_cnt", req_cnt, e_req);
      chk("resp_cnt", resp_cnt, e_resp);
      chk("beat_cnt", beat_cnt, e_beat);
      chk("lat_sum", lat_sum, e_sum);
      chk("lat_min", lat_min, e_min);
      chk("lat_max", lat_max, e_max);
      chk("outstanding", outstanding, e_out);
      chk("err_overflow", err_overflow, e_ovf);
      chk("err_orphan", err_orphan, e_orph);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_ar(input int id);
    ar_valid = 1'b1; ar_ready = 1'b1; ar_id = 8'(id);
    tick();
    ar_valid = 1'b0; ar_ready = 1'b0;
  endtask

  task automatic send_rlast(input int id);
    r_valid = 1'b1; r_ready = 1'b1; r_last = 1'b1; r_id = 8'(id);
    tick();
    r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
  endtask

  initial begin
    int guard;
    #1 resetN = 1'b0;
    #21 resetN = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rst_req", req_cnt, 0);
    chk("rst_lat_min", lat_min, 'hFFFF);
    chk("rst_outstanding", outstanding, 0);

    // single request, latency 100
    do_clear();
    send_ar(5);
    repeat (99) tick();
    send_rlast(5);
    chk("l100_req", req_cnt, 1);
    chk("l100_resp", resp_cnt, 1);
    chk("l100_sum", lat_sum, 100);
    chk("l100_min", lat_min, 100);
    chk("l100_max", lat_max, 100);

    // same-id in-order: ARs at 0,4,8 and last beats at 20,30,40
    do_clear();
    for (int c = 0; c <= 40; c++) begin
      ar_valid = (c == 0 || c == 4 || c == 8); ar_ready = 1'b1; ar_id = 8'd3;
      r_valid = (c == 20 || c == 30 || c == 40); r_ready = 1'b1; r_last = r_valid; r_id = 8'd3;
      tick();
    end
    ar_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    chk("ino_resp", resp_cnt, 3);
    chk("ino_min", lat_min, 20);
    chk("ino_max", lat_max, 32);
    chk("ino_sum", lat_sum, 78);
    chk("ino_outstanding", outstanding, 0);

    // orphan on empty table
    do_clear();
    send_rlast(7);
    chk("orph_flag", err_orphan, 1);
    chk("orph_resp", resp_cnt, 0);
    chk("orph_beat", beat_cnt, 1);

    // overflow: 33 requests into 32 entries
    do_clear();
    for (int i = 0; i < 33; i++) send_ar(i % 32);
    chk("ovf_outstanding", outstanding, 32);
    chk("ovf_req", req_cnt, 32);
    chk("ovf_flag", err_overflow, 1);
    send_rlast(0);
    chk("ovf_retire_out", outstanding, 31);
    chk("ovf_retire_resp", resp_cnt, 1);
    send_ar(9);
    chk("ovf_realloc_req", req_cnt, 33);
    chk("ovf_realloc_out", outstanding, 32);

    // randomized traffic
    do_clear();
    for (int c = 0; c < 3000; c++) begin
      ar_valid = ($urandom_range(0, 99) < 30);
      ar_ready = ($urandom_range(0, 3) != 0);
      ar_id    = 8'($urandom_range(0, 3));
      ar_len   = 8'($urandom);
      r_valid  = ($urandom_range(0, 99) < 40);
      r_ready  = ($urandom_range(0, 3) != 0);
      r_last   = 1'($urandom_range(0, 1));
      r_id     = 8'($urandom_range(0, 3));
      en       = ($urandom_range(0, 99) < 90);
      clear    = ($urandom_range(0, 199) == 0);
      tick();
    end
    ar_valid = 1'b0; ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    en = 1'b1; clear = 1'b0;

    // timestamp wrap: AR at 0xFFF0, last beat at 0x0010
    do_clear();
    guard = 0;
    while ((m_ts & 'hFFFF) != 'hFFF0 && guard < 70000) begin
      tick();
      guard++;
    end
    chk("wrap_reach", guard < 70000, 1);
    send_ar(1);
    guard = 0;
    while ((m_ts & 'hFFFF) != 'h0010 && guard < 100) begin
      tick();
      guard++;
    end
    send_rlast(1);
    chk("wrap_lat_max", lat_max, 'h20);
    chk("wrap_lat_min", lat_min, 'h20);

    // mid-cycle reset with four requests outstanding
    do_clear();
    for (int i = 10; i < 14; i++) send_ar(i);
    chk("rst4_outstanding", outstanding, 4);
    #3 resetN = 1'b0;
    #1;
    chk("rst4_req", req_cnt, 0);
    chk("rst4_outstanding0", outstanding, 0);
    chk("rst4_lat_min", lat_min, 'hFFFF);
    chk("rst4_lat_max", lat_max, 0);
    #12 resetN = 1'b1;
    tick();
    send_rlast(10);
    chk("rst4_orphan", err_orphan, 1);
    chk("rst4_resp", resp_cnt, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_rd_lat_mon.md
AXI_RD_LAT_MON -- requirements
Module: axi_rd_lat_mon

Interface
REQ-001 Parameters SHALL be: ID_WIDTH, default 8, AXI ID width; LOG_OUTSTAND, default 5, log2 of tracking-table entries; BURST_LEN_WIDTH, default 8, arlen width; LOG_BLOCK_DATA_BYTES, default 5, log2 of bytes per beat; CNT_WIDTH, default 32, width of statistics counters; LAT_WIDTH, default 16, width of timestamp and latency values.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, sole clock; resetN, in, 1, asynchronous active-low reset.
REQ-003 en, in, 1, sampling enable; clear, in, 1, synchronous statistics and table flush.
REQ-004 ar_valid, ar_ready, in, 1 each; ar_id, in, ID_WIDTH; ar_len, in, BURST_LEN_WIDTH: snooped read-address channel.
REQ-005 r_valid, r_ready, r_last, in, 1 each; r_id, in, ID_WIDTH: snooped read-data channel.
REQ-006 req_cnt, resp_cnt, beat_cnt, lat_sum, out, CNT_WIDTH each: accepted requests, completed bursts, data beats, latency sum.
REQ-007 lat_min, lat_max, out, LAT_WIDTH each; outstanding, out, LOG_OUTSTAND+1: live table entries.
REQ-008 err_overflow, err_orphan, out, 1 each: sticky error flags.

Function
REQ-009 The block SHALL be a passive monitor, driving no handshake signal.
REQ-010 A LAT_WIDTH free-running timestamp SHALL increment every cycle, wrap modulo 2^LAT_WIDTH, and run regardless of en.
REQ-011 AR handshake = ar_valid & ar_ready & en; R beat = r_valid & r_ready & en; R completion = R beat & r_last.
REQ-012 The table SHALL be a circular buffer of 2^LOG_OUTSTAND entries {valid, id, start timestamp}, with head and tail pointers.
REQ-013 On AR handshake with tail entry invalid: write {1, ar_id, timestamp} at tail, advance tail, increment req_cnt.
REQ-014 On AR handshake with tail entry valid (full): drop the request, set err_overflow, leave req_cnt unchanged.
REQ-015 On R completion, the matched entry SHALL be the first valid entry with id == r_id, searched from head toward tail (same-ID in-order).
REQ-016 Matched entry: invalidate; latency = (timestamp - start) mod 2^LAT_WIDTH; add latency zero-extended to lat_sum; update lat_min and lat_max; increment resp_cnt.
REQ-017 R completion with no match SHALL set err_orphan and change no other statistic except beat_cnt.
REQ-018 Every R beat SHALL increment beat_cnt, matched or not; bytes derive as beat_cnt << LOG_BLOCK_DATA_BYTES externally.
REQ-019 Head SHALL advance past invalid entries, at most one entry per cycle, never past tail.
REQ-020 Same cycle AR and R completion: R matches only pre-existing entries, never the entry allocated that cycle; both updates apply.
REQ-021 Same cycle AR and R completion when full: AR is judged on the pre-cycle tail state (dropped).
REQ-022 outstanding SHALL equal the count of valid entries, updated in the cycle following each event (+1, -1, or net 0).
REQ-023 All counters and lat_sum SHALL saturate at all-ones and never wrap.
REQ-024 Statistic outputs SHALL be registered, reflecting an event one cycle after its handshake.
REQ-025 clear SHALL zero all counters, lat_max, outstanding, and error flags, set lat_min to all-ones, and invalidate all entries with head = tail = 0.
REQ-026 clear SHALL override any same-cycle event; the timestamp SHALL NOT be cleared.
REQ-027 en low SHALL ignore handshakes while keeping table contents and outputs.

Reset
REQ-028 resetN low SHALL asynchronously drive all outputs to the clear state of REQ-025, zero the timestamp and pointers, and invalidate all entries, including mid-burst.
REQ-029 Responses belonging to requests lost by reset SHALL be reported as orphans.

Verification
REQ-030 AR id 5 at cycle 10, R last id 5 at cycle 110 -> req_cnt=1, resp_cnt=1, lat_sum=100, lat_min=lat_max=100.
REQ-031 ARs id 3 at cycles 0, 4, 8; R lasts id 3 at 20, 30, 40 -> latencies 20, 26, 32; lat_min=20, lat_max=32, lat_sum=78.
REQ-032 33 ARs without responses (LOG_OUTSTAND=5) -> outstanding=32, req_cnt=32, err_overflow=1; next R last id matching entry 0 retires entry 0 only.
REQ-033 R last id 7 with empty table -> err_orphan=1, resp_cnt=0, beat_cnt=1.
REQ-034 AR at timestamp 0xFFF0, R last at 0x0010 (LAT_WIDTH=16) -> latency 0x20.
REQ-035 Four outstanding, then resetN pulsed low mid-cycle -> outputs zero immediately and lat_min=0xFFFF; a later R last sets err_orphan.
